// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver
//   H-bridge PWM stage for one drive motor. Takes the decoded speed byte and
//   direction bit, ramps the applied duty toward the target once per PWM
//   period, and forces a ramp-down plus dead time on every direction reversal.
//
//   Ports:
//     clk_in        system clock
//     n_reset_in    asynchronous active-low reset
//     enable_in     1 = drive allowed, 0 = coast (both legs low, restart from IDLE)
//     speed_in      target duty, 0 = off, 255 = 100 %
//     direction_in  target direction, 1 = forward (plus leg), 0 = reverse (minus leg)
//     motor_plus    H-bridge forward leg (registered)
//     motor_minus   H-bridge reverse leg (registered)
//     duty_out      duty currently applied
//     state_out     00 IDLE, 01 DRIVE, 10 RAMP_DOWN, 11 DEAD
//     period_out    one-clk pulse on each PWM period boundary
module motor_pwm_driver #(
    parameter int unsigned CLK_DIV      = 1000,
    parameter int unsigned RAMP_STEP    = 4,
    parameter int unsigned DEAD_PERIODS = 2
) (
    input  logic       clk_in,
    input  logic       n_reset_in,
    input  logic       enable_in,
    input  logic [7:0] speed_in,
    input  logic       direction_in,
    output logic       motor_plus,
    output logic       motor_minus,
    output logic [7:0] duty_out,
    output logic [1:0] state_out,
    output logic       period_out
);

    localparam int unsigned PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned DC_W = $clog2(DEAD_PERIODS + 1);

    localparam logic [PS_W-1:0] PS_LAST   = PS_W'(CLK_DIV - 1);
    localparam logic [8:0]      STEP9     = 9'(RAMP_STEP);
    localparam logic [DC_W-1:0] DEAD_INIT = DC_W'(DEAD_PERIODS);
    localparam logic [7:0]      PWM_LAST  = 8'd254;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        DRIVE     = 2'b01,
        RAMP_DOWN = 2'b10,
        DEAD      = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      duty_q, duty_d;
    logic            dir_q, dir_d;
    logic [DC_W-1:0] dead_q, dead_d;
    logic [PS_W-1:0] prescaler_q, prescaler_d;
    logic [7:0]      pwm_q, pwm_d;
    logic            tick;
    logic            boundary;
    logic            drive_plus, drive_minus;

    // One ramp step of at most RAMP_STEP toward tgt, clamped so it never
    // overshoots. 9-bit math: bit 8 of the difference flags an underflow.
    function automatic logic [7:0] ramp_to(input logic [7:0] cur, input logic [7:0] tgt);
        logic [8:0] up;
        logic [8:0] dn;
        up = {1'b0, cur} + STEP9;
        dn = {1'b0, cur} - STEP9;
        if (tgt > cur)
            return (up > {1'b0, tgt}) ? tgt : up[7:0];
        else if (dn[8] || (dn < {1'b0, tgt}))
            return tgt;
        else
            return dn[7:0];
    endfunction

    always_comb begin
        state_d     = state_q;
        duty_d      = duty_q;
        dir_d       = dir_q;
        dead_d      = dead_q;
        prescaler_d = prescaler_q;
        pwm_d       = pwm_q;
        tick        = (prescaler_q == PS_LAST);
        boundary    = enable_in && tick && (pwm_q == PWM_LAST);

        if (!enable_in) begin
            state_d     = IDLE;
            duty_d      = '0;
            prescaler_d = '0;
            pwm_d       = '0;
        end else begin
            prescaler_d = tick ? '0 : prescaler_q + PS_W'(1);
            if (tick)
                pwm_d = (pwm_q == PWM_LAST) ? '0 : pwm_q + 8'd1;

            if (boundary) begin
                unique case (state_q)
                    IDLE: begin
                        dir_d   = direction_in;
                        duty_d  = ramp_to(duty_q, speed_in);
                        state_d = DRIVE;
                    end
                    DRIVE: begin
                        if (direction_in == dir_q) begin
                            duty_d = ramp_to(duty_q, speed_in);
                        end else if (duty_q != '0) begin
                            duty_d  = ramp_to(duty_q, '0);
                            state_d = RAMP_DOWN;
                        end else begin
                            dead_d  = DEAD_INIT;
                            state_d = DEAD;
                        end
                    end
                    RAMP_DOWN: begin
                        if (direction_in == dir_q) begin
                            duty_d  = ramp_to(duty_q, speed_in);
                            state_d = DRIVE;
                        end else begin
                            duty_d = ramp_to(duty_q, '0);
                            if (ramp_to(duty_q, '0) == '0) begin
                                dead_d  = DEAD_INIT;
                                state_d = DEAD;
                            end
                        end
                    end
                    DEAD: begin
                        dead_d = dead_q - DC_W'(1);
                        // Direction is only latched when leaving dead time, so
                        // late changes during DEAD are still honoured.
                        if (dead_q == DC_W'(1)) begin
                            dir_d   = direction_in;
                            state_d = DRIVE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state_q     <= IDLE;
            duty_q      <= '0;
            dir_q       <= 1'b1;
            dead_q      <= '0;
            prescaler_q <= '0;
            pwm_q       <= '0;
        end else begin
            state_q     <= state_d;
            duty_q      <= duty_d;
            dir_q       <= dir_d;
            dead_q      <= dead_d;
            prescaler_q <= prescaler_d;
            pwm_q       <= pwm_d;
        end
    end

    // Leg selection from the current state; the registers below add the
    // one-clk output latency. At most one leg can be selected by dir_q.
    always_comb begin
        drive_plus  = 1'b0;
        drive_minus = 1'b0;
        if ((state_q == DRIVE) || (state_q == RAMP_DOWN)) begin
            drive_plus  = dir_q && (pwm_q < duty_q);
            drive_minus = !dir_q && (pwm_q < duty_q);
        end
    end

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            motor_plus  <= 1'b0;
            motor_minus <= 1'b0;
        end else if (!enable_in) begin
            motor_plus  <= 1'b0;
            motor_minus <= 1'b0;
        end else begin
            motor_plus  <= drive_plus;
            motor_minus <= drive_minus;
        end
    end

    assign duty_out   = duty_q;
    assign state_out  = state_q;
    assign period_out = boundary;

endmodule
